// File: rtl/laser_distance_pkg.sv
// Shared encodings and limits for the laser distance-meter controller.
package laser_distance_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] TIMEOUT_MAX = 16'hFFFE;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_FIRE  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/laser_distance_ctl_edge_detect_rise.sv
// Rising-edge detector: one history flop plus an AND.
module edge_detect_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  assign d_d  = d;
  assign rise = d & ~d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d_d;
  end

endmodule

// File: rtl/laser_distance_ctl.sv
// Laser distance-meter sequencer: fire, count round trip, capture or time out.
// LASER_DISTANCE_CONTINUOUS_EN: re-fire from S_DONE while start is held.
module laser_distance_ctl
  import laser_distance_pkg::*;
#(
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(60000)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sensor,
  output logic laser,
  output logic Qclr,
  output logic Dclr,
  output logic Dinc,
  output logic Qupd,
  output logic busy,
  output logic done,
  output logic timeout
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            rise;
  logic            to_hit;

  edge_detect_rise u_start_edge (
    .clk   (clk),
    .reset (reset),
    .d     (start),
    .rise  (rise)
  );

  assign to_hit  = (to_cnt_q == TIMEOUT - 1'b1);
  assign timeout = timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_INIT;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    laser     = 1'b0;
    Qclr      = 1'b0;
    Dclr      = 1'b0;
    Dinc      = 1'b0;
    Qupd      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_INIT: begin
        Qclr    = 1'b1;
        Dclr    = 1'b1;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        Dclr = 1'b1;
        if (rise) begin
          timeout_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = S_FIRE;
        end
      end
      S_FIRE: begin
        laser   = 1'b1;
        Dinc    = 1'b1;
        busy    = 1'b1;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        busy = 1'b1;
        // A return in the compare cycle still yields a valid range.
        if (sensor) begin
          Qupd    = 1'b1;
          state_d = S_DONE;
        end else if (to_hit) begin
          Qclr      = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          Dinc     = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        Dclr    = 1'b1;
        state_d = S_IDLE;
`ifdef LASER_DISTANCE_CONTINUOUS_EN
        if (start) begin
          timeout_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = S_FIRE;
        end
`endif
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_laser_distance_ctl.sv
// Randomized bench for laser_distance_ctl with an attached Dctr/Q datapath.
module tb_laser_distance_ctl;

  localparam int TO = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sensor = 1'b0;
  logic laser, Qclr, Dclr, Dinc, Qupd, busy, done, timeout;
  logic [15:0] dctr, q;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  laser_distance_ctl #(
    .TO_W    (16),
    .TIMEOUT (16'(TO))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sensor  (sensor),
    .laser   (laser),
    .Qclr    (Qclr),
    .Dclr    (Dclr),
    .Dinc    (Dinc),
    .Qupd    (Qupd),
    .busy    (busy),
    .done    (done),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (Dclr)      dctr <= '0;
    else if (Dinc) dctr <= dctr + 16'd1;
    if (Qclr)      q <= '0;
    else if (Qupd) q <= dctr >> 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k = COUNT cycle on which the return arrives (k > TO means never).
  task automatic run_meas(input int k);
    int e_dinc, e_busy, e_q, e_tmo, e_qupd, e_qclr;
    int n_laser, n_dinc, n_busy, n_qupd, n_qclr;
    int cyc, end_cyc, done_cyc, laser_cyc;
    bit seen;
    if (k >= 1 && k <= TO) begin
      e_dinc = k;  e_busy = k + 1; e_q = k / 2;
      e_tmo = 0;   e_qupd = 1;     e_qclr = 0;
    end else begin
      e_dinc = TO; e_busy = TO + 1; e_q = 0;
      e_tmo = 1;   e_qupd = 0;      e_qclr = 1;
    end
    n_laser = 0; n_dinc = 0; n_busy = 0; n_qupd = 0; n_qclr = 0;
    cyc = 0; end_cyc = -1; done_cyc = -1; laser_cyc = -1; seen = 0;
    @(negedge clk);
    start = 1'b0;
    sensor = 1'($urandom);
    @(negedge clk);
    start = 1'b1;
    sensor = 1'($urandom);
    while (!seen && cyc < TO + 10) begin
      @(negedge clk);
      cyc++;
      start  = (cyc <= e_busy) ? 1'($urandom) : 1'b0;
      if (cyc == 1)          sensor = 1'($urandom);
      else if (cyc - 1 == k) sensor = 1'b1;
      else                   sensor = 1'b0;
      #1;
      if (cyc == 1) chk("tmo_clear_at_fire", timeout, 0);
      if (laser && laser_cyc < 0) laser_cyc = cyc;
      n_laser += int'(laser);
      n_dinc  += int'(Dinc);
      n_busy  += int'(busy);
      n_qupd  += int'(Qupd);
      if (busy) n_qclr += int'(Qclr);
      if (busy && (Qupd || Qclr)) end_cyc = cyc;
      if (done) begin
        seen = 1;
        done_cyc = cyc;
      end
    end
    chk("done_seen", seen, 1);
    chk("laser_slot", laser_cyc, 1);
    chk("laser_cycles", n_laser, 1);
    chk("dinc_cycles", n_dinc, e_dinc);
    chk("busy_cycles", n_busy, e_busy);
    chk("qupd_cycles", n_qupd, e_qupd);
    chk("qclr_cycles", n_qclr, e_qclr);
    chk("done_latency", done_cyc - end_cyc, 1);
    @(negedge clk);
    start = 1'b0;
    sensor = 1'($urandom);
    #1;
    chk("distance", q, e_q);
    chk("timeout_flag", timeout, e_tmo);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_dclr", Dclr, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_qclr", Qclr, 1);
    chk("rst_dclr", Dclr, 1);
    chk("rst_out0", {laser, Dinc, Qupd, busy, done, timeout}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("init_qclr", Qclr, 1);
    chk("init_dclr", Dclr, 1);
    @(negedge clk);
    #1;
    chk("idle_qclr", Qclr, 0);
    chk("idle_dclr0", Dclr, 1);
    chk("idle_out0", {laser, Dinc, Qupd, busy, done}, 0);
    chk("reset_q", q, 0);

    run_meas(11);
    run_meas(TO + 5);
    repeat (3) begin
      @(negedge clk);
      sensor = 1'($urandom);
      #1;
      chk("tmo_sticky", timeout, 1);
    end
    run_meas(TO);
    run_meas(1);
    for (int i = 0; i < 12; i++) run_meas(int'($urandom_range(1, TO + 3)));

    // Reset in the middle of COUNT with start held high throughout.
    run_meas(9);
    @(negedge clk);
    start = 1'b1;
    sensor = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_qclr", Qclr, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sensor = 1'($urandom);
      #1;
      chk("held_start_idle", busy, 0);
    end
    chk("midrst_q", q, 0);
    run_meas(4);

`ifdef LASER_DISTANCE_CONTINUOUS_EN
    begin
      int last, pulses, cyc;
      last = -1; pulses = 0; cyc = 0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      while (cyc < 40) begin
        @(negedge clk);
        cyc++;
        sensor = (last >= 0 && cyc - last == 5);
        #1;
        if (laser) begin
          if (last >= 0) begin
            chk("cont_gap", cyc - last, 7);
            chk("cont_q", q, 2);
          end
          last = cyc;
          pulses++;
        end
      end
      chk("cont_pulses_ge3", pulses >= 3, 1);
      @(negedge clk);
      start = 1'b0;
      sensor = 1'b0;
      repeat (10) @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
